// File: rtl/div_iter_if.sv
// Request/response bundle for the iterative divider: one request channel, one result pulse.
// Latency: none (wires only).
// Backpressure: the request side obeys in_ready; the result side has none (sample res on out_valid).
interface div_iter_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic [1:0]      op;
  logic            kill;
  logic            out_valid;
  logic [XLEN-1:0] res;

  // Issuing side (execute stage / bench)
  modport master (
    output in_valid, a, b, op, kill,
    input  in_ready, out_valid, res
  );

  // Divider side
  modport slave (
    input  in_valid, a, b, op, kill,
    output in_ready, out_valid, res
  );
endinterface

// File: rtl/div_iter.sv
// Iterative radix-2 restoring divider for DIV/DIVU/REM/REMU, one operation in flight.
// Latency: out_valid in the XLEN+1'th cycle after the accepting edge (2nd cycle for
//   b==0 / signed overflow when DIV_EARLY_OUT_EN is defined); in_ready returns the cycle after.
// Backpressure: in_ready low while busy; no output backpressure, res held until the next result.
// op encoding: 0 DIV, 1 DIVU, 2 REM, 3 REMU (bit0 = unsigned, bit1 = return remainder).
module div_iter #(
  parameter int XLEN = 32
) (
  input  logic       clk,
  input  logic       reset,
  div_iter_if.slave  bus
);

  localparam int CW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

`ifdef DIV_EARLY_OUT_EN
  localparam bit EARLY_OUT = 1'b1;
`else
  localparam bit EARLY_OUT = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_q;
  logic            in_ready_q;
  logic            out_valid_q;
  logic [XLEN-1:0] res_q;
  logic [XLEN-1:0] rem_q;
  logic [XLEN-1:0] quo_q;
  logic [XLEN-1:0] dvs_q;
  logic [XLEN-1:0] a_q;
  logic [CW-1:0]   cnt_q;
  logic            rem_sel_q;
  logic            neg_quo_q;
  logic            neg_rem_q;
  logic            zero_q;
  logic            ovf_q;

  // Request decode: signedness, operand magnitudes and the two special cases
  logic            op_signed_d;
  logic            sign_a_d;
  logic            sign_b_d;
  logic [XLEN-1:0] abs_a_d;
  logic [XLEN-1:0] abs_b_d;
  logic            b_zero_d;
  logic            ovf_d;
  logic            accept_d;
  logic [CW-1:0]   cnt_start_d;

  // Decode the incoming request; only consumed in IDLE
  always_comb begin
    op_signed_d = ~bus.op[0];
    sign_a_d    = op_signed_d & bus.a[XLEN-1];
    sign_b_d    = op_signed_d & bus.b[XLEN-1];
    abs_a_d     = sign_a_d ? (-bus.a) : bus.a;
    abs_b_d     = sign_b_d ? (-bus.b) : bus.b;
    b_zero_d    = (bus.b == '0);
    ovf_d       = op_signed_d && (bus.a == MIN_NEG) && (bus.b == '1);
    accept_d    = bus.in_valid & in_ready_q & ~bus.kill;
    // Early-out reuses the last BUSY step: the forced result is picked in the final fix-up
    cnt_start_d = (EARLY_OUT && (b_zero_d || ovf_d)) ? '0 : CW'(XLEN - 1);
  end

  // One restoring step plus the result fix-up applied on the final step
  logic [XLEN:0]   rem_sh_d;
  logic [XLEN:0]   dif_d;
  logic            ge_d;
  logic [XLEN-1:0] rem_nx_d;
  logic [XLEN-1:0] quo_nx_d;
  logic [XLEN-1:0] quo_fix_d;
  logic [XLEN-1:0] rem_fix_d;
  logic [XLEN-1:0] res_d;

  // Shift-subtract step and sign / special-case correction of the outcome
  always_comb begin
    rem_sh_d = {rem_q, quo_q[XLEN-1]};
    dif_d    = rem_sh_d - {1'b0, dvs_q};
    // rem < divisor is invariant, so the difference sign bit is a clean compare
    ge_d     = ~dif_d[XLEN];
    rem_nx_d = ge_d ? dif_d[XLEN-1:0] : rem_sh_d[XLEN-1:0];
    quo_nx_d = {quo_q[XLEN-2:0], ge_d};

    if (zero_q) begin
      quo_fix_d = '1;
      rem_fix_d = a_q;
    end else if (ovf_q) begin
      quo_fix_d = MIN_NEG;
      rem_fix_d = '0;
    end else begin
      quo_fix_d = neg_quo_q ? (-quo_nx_d) : quo_nx_d;
      rem_fix_d = neg_rem_q ? (-rem_nx_d) : rem_nx_d;
    end
    res_d = rem_sel_q ? rem_fix_d : quo_fix_d;
  end

  // Control FSM with registered handshake outputs and datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      res_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      dvs_q       <= '0;
      a_q         <= '0;
      cnt_q       <= '0;
      rem_sel_q   <= 1'b0;
      neg_quo_q   <= 1'b0;
      neg_rem_q   <= 1'b0;
      zero_q      <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          out_valid_q <= 1'b0;
          if (accept_d) begin
            state_q    <= BUSY;
            in_ready_q <= 1'b0;
            rem_q      <= '0;
            quo_q      <= abs_a_d;
            dvs_q      <= abs_b_d;
            a_q        <= bus.a;
            cnt_q      <= cnt_start_d;
            rem_sel_q  <= bus.op[1];
            neg_quo_q  <= sign_a_d ^ sign_b_d;
            neg_rem_q  <= sign_a_d;
            zero_q     <= b_zero_d;
            ovf_q      <= ovf_d;
          end
        end
        BUSY: begin
          if (bus.kill) begin
            state_q    <= IDLE;
            in_ready_q <= 1'b1;
          end else begin
            rem_q <= rem_nx_d;
            quo_q <= quo_nx_d;
            cnt_q <= cnt_q - 1'b1;
            if (cnt_q == '0) begin
              state_q     <= DONE;
              out_valid_q <= 1'b1;
              res_q       <= res_d;
            end
          end
        end
        DONE: begin
          // Result already committed; a kill here changes nothing
          state_q     <= IDLE;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
        end
        default: begin
          state_q     <= IDLE;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.res       = res_q;

endmodule

// File: tb/tb_div_iter.sv
// Scoreboard bench for div_iter: expected result and latency queued at issue, checked on out_valid.
// Define DIV_EARLY_OUT_EN for both RTL and bench to exercise the early-out latency.
module tb_div_iter;

  localparam logic [1:0] DIV = 2'd0, DIVU = 2'd1, REM = 2'd2, REMU = 2'd3;
  localparam int LAT = 33;
`ifdef DIV_EARLY_OUT_EN
  localparam int LAT_SPC = 2;
`else
  localparam int LAT_SPC = 33;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  div_iter_if #(.XLEN(32)) bus ();

  div_iter #(.XLEN(32)) dut (
    .clk   (clk),
    .reset (rst),
    .bus   (bus)
  );

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;
  int n_out  = 0;

  logic [31:0] exp_q[$];
  int          lat_q[$];
  int          acc_q[$];
  int          out_cyc[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, obs, exp);
  endtask

  function automatic logic [31:0] ref_div(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    if (b == 32'h0) return op[1] ? a : 32'hFFFF_FFFF;
    if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return op[1] ? 32'h0 : 32'h8000_0000;
    case (op)
      DIV:     return $signed(a) / $signed(b);
      REM:     return $signed(a) % $signed(b);
      DIVU:    return a / b;
      default: return a % b;
    endcase
  endfunction

  function automatic int ref_lat(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    if (b == 32'h0) return LAT_SPC;
    if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return LAT_SPC;
    return LAT;
  endfunction

  // Result monitor: pop the oldest expectation on each out_valid pulse
  always @(negedge clk) begin
    if (!rst && bus.out_valid) begin
      n_out++;
      out_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        chk("spurious out_valid", 32'd1, 32'd0);
      end else begin
        chk("result", bus.res, exp_q.pop_front());
        chk("latency", 32'(cyc - acc_q.pop_front()), 32'(lat_q.pop_front()));
      end
    end
  end

  // Present one request at a negedge once in_ready is seen, leave garbage behind after acceptance
  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input int lat, input bit push, input bit hold);
    int n = 0;
    @(negedge clk);
    while (!bus.in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) begin
      chk("accept timeout", 32'(bus.in_ready), 32'd1);
      return;
    end
    bus.op = op; bus.a = a; bus.b = b; bus.in_valid = 1'b1;
    if (push) begin
      exp_q.push_back(exp);
      lat_q.push_back(lat);
      acc_q.push_back(cyc);
    end
    @(posedge clk);
    #1;
    bus.a  = $urandom;
    bus.b  = $urandom;
    bus.op = 2'($urandom_range(3));
    if (!hold) bus.in_valid = 1'b0;
  endtask

  task automatic go(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
    issue(op, a, b, exp, ref_lat(op, a, b), 1'b1, 1'b0);
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) chk("drain timeout", 32'(exp_q.size()), 32'd0);
    @(negedge clk);
  endtask

  initial begin
    int base;
    int seen;
    logic [1:0]  rop;
    logic [31:0] ra, rb;

    bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.op = '0; bus.kill = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset in_ready", 32'(bus.in_ready), 32'd1);
    chk("reset out_valid", 32'(bus.out_valid), 32'd0);
    chk("reset res", bus.res, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Directed cases
    go(DIVU, 32'd100, 32'd7, 32'd14);
    drain();
    go(DIV,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
    drain();
    go(REM,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
    drain();
    go(REM,  32'd7, 32'hFFFF_FFFE, 32'd1);
    drain();
    go(DIV,  32'd5, 32'd0, 32'hFFFF_FFFF);
    drain();
    go(REM,  32'd5, 32'd0, 32'd5);
    drain();
    go(DIVU, 32'hFFFF_FFFF, 32'd0, 32'hFFFF_FFFF);
    drain();
    go(REM,  32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB);
    drain();
    go(REMU, 32'h8000_0003, 32'd0, 32'h8000_0003);
    drain();
    go(DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
    drain();
    go(REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0);
    drain();
    go(DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);
    drain();

    // Random operands against the reference model
    for (int i = 0; i < 10; i++) begin
      rop = 2'($urandom_range(3));
      ra  = $urandom;
      rb  = (i % 3 == 0) ? 32'($urandom_range(15)) : $urandom;
      go(rop, ra, rb, ref_div(rop, ra, rb));
      drain();
    end

    go(REMU, 32'd100, 32'd7, 32'd2);
    drain();

    // Kill in IDLE together with in_valid: must not be accepted
    @(negedge clk);
    bus.op = DIVU; bus.a = 32'd9; bus.b = 32'd3; bus.in_valid = 1'b1; bus.kill = 1'b1;
    @(posedge clk);
    #1;
    chk("kill idle in_ready", 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b0; bus.kill = 1'b0;

    // Kill mid-operation: no result, res keeps previous value
    seen = n_out;
    issue(DIVU, 32'd100, 32'd7, 32'd0, 0, 1'b0, 1'b0);
    chk("busy in_ready", 32'(bus.in_ready), 32'd0);
    repeat (8) @(posedge clk);
    @(negedge clk);
    bus.kill = 1'b1;
    @(posedge clk);
    #1;
    bus.kill = 1'b0;
    chk("kill in_ready", 32'(bus.in_ready), 32'd1);
    chk("kill res held", bus.res, 32'd2);
    repeat (40) @(negedge clk);
    chk("kill no out_valid", 32'(n_out), 32'(seen));

    // Async reset mid-operation
    issue(DIVU, 32'd100, 32'd7, 32'd0, 0, 1'b0, 1'b0);
    repeat (19) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("rst in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst res", bus.res, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    chk("rst no out_valid", 32'(n_out), 32'(seen));

    // Kill during DONE: pulse still delivered, then idle
    go(DIV, 32'd12, 32'hFFFF_FFFD, 32'hFFFF_FFFC);
    begin
      int n = 0;
      while (!bus.out_valid && n < 100) begin
        @(negedge clk);
        n++;
      end
    end
    chk("done out_valid", 32'(bus.out_valid), 32'd1);
    bus.kill = 1'b1;
    @(posedge clk);
    #1;
    bus.kill = 1'b0;
    chk("done kill in_ready", 32'(bus.in_ready), 32'd1);
    drain();

    // Back-to-back with in_valid held and garbage presented while busy
    base = out_cyc.size();
    issue(DIVU, 32'd1000, 32'd3, 32'd333, LAT, 1'b1, 1'b1);
    issue(REM, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFFE, LAT, 1'b1, 1'b1);
    issue(DIV, 32'd12345, 32'hFFFF_FFFB, 32'hFFFF_F65B, LAT, 1'b1, 1'b0);
    drain();
    if (out_cyc.size() >= base + 3) begin
      chk("b2b spacing 1", 32'(out_cyc[base+1] - out_cyc[base]), 32'd34);
      chk("b2b spacing 2", 32'(out_cyc[base+2] - out_cyc[base+1]), 32'd34);
    end else begin
      chk("b2b pulse count", 32'(out_cyc.size() - base), 32'd3);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  // Global watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

endmodule
